// File: rtl/load_store_unit_if.sv
// Single-beat memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word pipeline requests into single-beat
// word-aligned bus transfers, with misalignment detection and an ack timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        we_mem,
  input  logic        is_signed,
  input  logic [1:0]  word_length,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  load_store_unit_if.master mem
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_t;

  typedef struct packed {
    logic       is_load;
    logic       is_signed;
    size_t      size;
    logic [1:0] lane;
  } req_t;

  state_t           state;
  req_t             cap;
  logic [CNT_W-1:0] cnt;

  size_t       size_c;
  logic        misaligned_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        accept_c;

  // Decode the incoming request; word_length 11 is folded into word.
  always_comb begin
    size_c       = SZ_WORD;
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = wdata;
    accept_c     = req_valid & (is_load | we_mem);
    case (word_length)
      2'b00:   size_c = SZ_BYTE;
      2'b01:   size_c = SZ_HALF;
      default: size_c = SZ_WORD;
    endcase
    case (size_c)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        misaligned_c = addr[0];
        be_c         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{wdata[15:0]}};
      end
      default: begin
        misaligned_c = (addr[1:0] != 2'b00);
        be_c         = 4'b1111;
        wdata_c      = wdata;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned word; stores read back 0.
  function automatic logic [31:0] extend(input req_t r, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (r.lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = r.lane[1] ? d[31:16] : d[15:0];
    case (r.size)
      SZ_BYTE: res = {{24{r.is_signed & b[7]}}, b};
      SZ_HALF: res = {{16{r.is_signed & h[15]}}, h};
      default: res = d;
    endcase
    return r.is_load ? res : 32'd0;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cap           <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rdata         <= '0;
      misaligned    <= 1'b0;
      bus_err       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            cap.is_load   <= is_load;
            cap.is_signed <= is_signed;
            cap.size      <= size_c;
            cap.lane      <= addr[1:0];
            busy          <= 1'b1;
            if (misaligned_c) begin
              state      <= RESP;
              done       <= 1'b1;
              misaligned <= 1'b1;
              rdata      <= '0;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= we_mem & ~is_load;
              mem.mem_addr  <= {addr[31:2], 2'b00};
              mem.mem_be    <= be_c;
              mem.mem_wdata <= wdata_c;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack || (cnt == CNT_W'(TIMEOUT - 1))) begin
            state         <= RESP;
            done          <= 1'b1;
            bus_err       <= ~mem.mem_ack;
            rdata         <= mem.mem_ack ? extend(cap, mem.mem_rdata) : 32'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout, reset and back-to-back sequences.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_load = 1'b0;
  logic        we_mem = 1'b0;
  logic        is_signed = 1'b0;
  logic [1:0]  word_length = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit_if mem_bus();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load),
    .we_mem(we_mem), .is_signed(is_signed), .word_length(word_length),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .bus_err(bus_err), .mem(mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st, sg;
    logic [1:0]  wl;
    logic [31:0] a, wd, mrd;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    logic        e_mis;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic sg,
                       input logic [1:0] wl, input logic [31:0] a, input logic [31:0] wd);
    is_load = ld; we_mem = st; is_signed = sg; word_length = wl; addr = a; wdata = wd;
    req_valid = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.ld, v.st, v.sg, v.wl, v.a, v.wd);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.e_mis) begin
      chk({t, "_mis_done"}, 32'(done), 32'd1);
      chk({t, "_mis_flag"}, 32'(misaligned), 32'd1);
      chk({t, "_mis_req"}, 32'(mem_bus.mem_req), 32'd0);
      chk({t, "_mis_rdata"}, rdata, v.e_rd);
    end else begin
      chk({t, "_req"}, 32'(mem_bus.mem_req), 32'd1);
      chk({t, "_we"}, 32'(mem_bus.mem_we), 32'(v.e_we));
      chk({t, "_be"}, 32'(mem_bus.mem_be), 32'(v.e_be));
      chk({t, "_addr"}, mem_bus.mem_addr, v.e_addr);
      chk({t, "_wdata"}, mem_bus.mem_wdata, v.e_wd);
      chk({t, "_busy"}, 32'(busy), 32'd1);
      chk({t, "_early_done"}, 32'(done), 32'd0);
      mem_bus.mem_ack = 1'b1;
      mem_bus.mem_rdata = v.mrd;
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      chk({t, "_done"}, 32'(done), 32'd1);
      chk({t, "_mis"}, 32'(misaligned), 32'd0);
      chk({t, "_err"}, 32'(bus_err), 32'd0);
      chk({t, "_rdata"}, rdata, v.e_rd);
      chk({t, "_req_drop"}, 32'(mem_bus.mem_req), 32'd0);
    end
    @(negedge clk);
    chk({t, "_idle_busy"}, 32'(busy), 32'd0);
    chk({t, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int ndone;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;

    //        ld    st    sg    wl     addr          wdata         mem_rdata     we    be       maddr         mwdata        mis   rdata
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0022, 32'h1234_ABCD, 32'h0,        1'b1, 4'b1100, 32'h0000_0020, 32'hABCD_ABCD, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0041, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0001, 32'h0,        32'h0000_9A00, 1'b0, 4'b0010, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_009A};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0002, 32'h0,        32'h8001_1234, 1'b0, 4'b1100, 32'h0000_0000, 32'h0,        1'b0, 32'hFFFF_8001};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0000, 32'h0,        32'h8001_F234, 1'b0, 4'b0011, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_F234};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0007, 32'h0000_00A5, 32'h0,        1'b1, 4'b1000, 32'h0000_0004, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0000_0008, 32'h0,        1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_000C, 32'h5555_AAAA, 32'h1122_3344, 1'b0, 4'b1111, 32'h0000_000C, 32'h5555_AAAA, 1'b0, 32'h1122_3344};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0003, 32'h1111_2222, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0,        32'hFFFF_FF7F, 1'b0, 4'b0001, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_007F};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0201, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_be", 32'(mem_bus.mem_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Ack while idle must be ignored
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("idle_ack_done", 32'(done), 32'd0);
    chk("idle_ack_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Timeout: LHU with ack withheld
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0002, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    nreq = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mem_bus.mem_req) nreq++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(nreq), 32'd4);
    chk("to_done", 32'(done), 32'd1);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_rdata", rdata, 32'd0);
    chk("to_req_drop", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_err_pulse", 32'(bus_err), 32'd0);

    // Reset in the middle of a LW, then a late ack
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rr_req_before", 32'(mem_bus.mem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rr_req_async", 32'(mem_bus.mem_req), 32'd0);
    chk("rr_busy_async", 32'(busy), 32'd0);
    chk("rr_addr_async", mem_bus.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("rr_no_done", 32'(ndone), 32'd0);

    // req_valid held high through an LBU: second request only after RESP
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0001, 32'h0);
    @(negedge clk);
    chk("hold_req", 32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h0000_9A00;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_rdata", rdata, 32'h0000_009A);
    chk("hold_resp_busy", 32'(busy), 32'd1);
    chk("hold_resp_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 32'd0);
    chk("hold_idle_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_second_busy", 32'(busy), 32'd1);
    chk("hold_second_req", 32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h0000_8000;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("hold_second_done", 32'(done), 32'd1);
    chk("hold_second_rdata", rdata, 32'h0000_0080);
    @(negedge clk);
    chk("hold_end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, 255, maximum cycles in REQ awaiting mem_ack before abort.
REQ-002 Clock and reset SHALL be a single clock and an asynchronous active-low reset:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
REQ-003 Pipeline-side ports SHALL be:
- req_valid  input  1  request strobe
- is_load  input  1  load request
- we_mem  input  1  store request
- is_signed  input  1  sign-extend load
- word_length  input  2  00 byte, 01 half, 10 word
- addr  input  32  byte address
- wdata  input  32  store data
- busy  output  1  stall, high while state != IDLE
- done  output  1  one-cycle completion pulse
- rdata  output  32  extended load result
- misaligned  output  1  one-cycle pulse with done
- bus_err  output  1  one-cycle pulse with done
REQ-004 Memory-side ports SHALL be:
- mem_req  output  1  bus request
- mem_we  output  1  write enable
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  single-beat acknowledge
- mem_rdata  input  32  read word, valid with mem_ack

Function
REQ-005 The FSM SHALL have states IDLE, REQ, RESP; busy SHALL equal (state != IDLE).
REQ-006 In IDLE, req_valid with is_load or we_mem high SHALL capture all request inputs and move to REQ next cycle; otherwise the unit SHALL stay in IDLE.
REQ-007 When is_load and we_mem are both high, the request SHALL be treated as a load.
REQ-008 word_length 11 SHALL be treated as word.
REQ-009 A misaligned request SHALL go to RESP without asserting mem_req:
- half with addr[0]=1
- word with addr[1:0]!=00
In RESP, misaligned=1 and rdata=0.
REQ-010 In REQ, mem_req SHALL be 1, and mem_we, mem_addr, mem_be and mem_wdata SHALL be driven from the captured request.
REQ-011 mem_be SHALL be:
- byte: 1<<addr[1:0]
- half: 0011 if addr[1]=0, else 1100
- word: 1111
The same enables SHALL be driven for loads.
REQ-012 mem_wdata SHALL be:
- byte: {4{wdata[7:0]}}
- half: {2{wdata[15:0]}}
- word: wdata
REQ-013 mem_ack high in REQ SHALL register mem_rdata and move to RESP; mem_req SHALL be low from the next cycle.
REQ-014 The timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack; after TIMEOUT ackless cycles the unit SHALL go to RESP with bus_err=1 and rdata=0.
REQ-015 RESP SHALL last exactly one cycle with done=1, then return to IDLE; req_valid in REQ or RESP SHALL be ignored.
REQ-016 Load rdata SHALL select the lane addressed by addr[1:0] or addr[1], then sign-extend when is_signed=1, else zero-extend. For stores, rdata SHALL be 0.
REQ-017 Minimum latency SHALL be 3 cycles from acceptance to done (ack in the first REQ cycle). Misaligned requests SHALL complete with done one cycle after acceptance.
REQ-018 mem_ack outside REQ SHALL be ignored.

Reset
REQ-019 When rst=0, the unit SHALL be forced asynchronously to IDLE with:
- busy=done=misaligned=bus_err=mem_req=mem_we=0
- mem_be=0, mem_addr=0, mem_wdata=0, rdata=0
- timeout counter=0
REQ-020 Reset mid-transaction SHALL drop mem_req immediately, and a late mem_ack after reset release SHALL be ignored.

Verification
REQ-021 LB, addr=0x103, is_signed=1, mem_rdata=0x80FF_FF00 acked in the first REQ cycle -> mem_be=1000, mem_addr=0x100, done at cycle 3, rdata=0xFFFF_FF80.
REQ-022 SH, addr=0x22, wdata=0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x20, rdata=0.
REQ-023 LW, addr=0x41 -> mem_req never asserted; done=1 and misaligned=1 one cycle after acceptance; rdata=0.
REQ-024 LHU, addr=0x2, mem_ack withheld, TIMEOUT=4 -> 4 REQ cycles, then done=1, bus_err=1, rdata=0, unit returns to IDLE.
REQ-025 rst pulled low during REQ of LW, then mem_ack arrives after release -> mem_req=0 immediately, no done pulse, busy=0.
REQ-026 req_valid held high through LBU at addr=0x1 with mem_rdata=0x0000_9A00 -> rdata=0x0000_009A; the second request is accepted only after RESP.
